// File: rtl/lcd_mode_scheduler.sv
// rtl/lcd_mode_scheduler.sv - shares a 16x2 character LCD between mode blocks
// Sweeps screen index 0..31, writing line-address commands and the active mode's characters.
module lcd_mode_scheduler #(
  parameter int NUM_MODES = 4,
  parameter int SETTLE    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_btn,
  input  logic                   en_time,
  input  logic [8*NUM_MODES-1:0] char_in,
  output logic [4:0]             index,
  output logic [1:0]             mode,
  output logic [NUM_MODES-1:0]   mode_en,
  output logic [7:0]             lcd_data,
  output logic                   lcd_rs,
  output logic                   lcd_wr,
  input  logic                   lcd_ready,
  output logic                   frame_done
);

  typedef enum logic [1:0] {
    ST_ADDR,
    ST_SETTLE,
    ST_CHAR
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [1:0] LAST_MODE   = 2'(NUM_MODES - 1);

  state_t               state, state_d;
  logic [3:0]           settle_cnt, settle_cnt_d;
  logic                 pend_next, pend_next_d;
  logic                 pend_watch, pend_watch_d;
  logic [4:0]           index_d;
  logic [1:0]           mode_d;
  logic [NUM_MODES-1:0] mode_en_d;
  logic [7:0]           lcd_data_d;
  logic                 lcd_rs_d;
  logic                 lcd_wr_d;
  logic                 frame_done_d;
  logic [7:0]           char_sel;
  logic                 xfer;

  assign xfer = lcd_wr & lcd_ready;

  always_comb begin
    char_sel = 8'h00;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode == 2'(m)) char_sel = char_in[8*m +: 8];
    end
  end

  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    index_d      = index;
    mode_d       = mode;
    mode_en_d    = mode_en;
    lcd_data_d   = lcd_data;
    lcd_rs_d     = lcd_rs;
    lcd_wr_d     = lcd_wr;
    frame_done_d = 1'b0;
    // Requests stay sticky so a frame is always drawn from a single mode
    pend_next_d  = pend_next | mode_btn;
    pend_watch_d = pend_watch | (en_time && mode == 2'd1);

    case (state)
      ST_ADDR: begin
        lcd_wr_d   = 1'b1;
        lcd_rs_d   = 1'b0;
        lcd_data_d = index[4] ? 8'hC0 : 8'h80;
        if (xfer) begin
          lcd_wr_d     = 1'b0;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        lcd_wr_d = 1'b0;
        if (settle_cnt == 4'd0) begin
          lcd_data_d = char_sel;
          lcd_rs_d   = 1'b1;
          lcd_wr_d   = 1'b1;
          state_d    = ST_CHAR;
        end else begin
          settle_cnt_d = settle_cnt - 4'd1;
        end
      end
      ST_CHAR: begin
        if (xfer) begin
          if (index == 5'd15) begin
            index_d    = 5'd16;
            lcd_rs_d   = 1'b0;
            lcd_data_d = 8'hC0;
            state_d    = ST_ADDR;
          end else if (index == 5'd31) begin
            index_d      = 5'd0;
            lcd_rs_d     = 1'b0;
            lcd_data_d   = 8'h80;
            frame_done_d = 1'b1;
            state_d      = ST_ADDR;
            if (pend_watch_d) begin
              mode_d = 2'd0;
            end else if (pend_next_d) begin
              mode_d = (mode == LAST_MODE) ? 2'd0 : mode + 2'd1;
            end
            pend_next_d  = 1'b0;
            pend_watch_d = 1'b0;
          end else begin
            index_d      = index + 5'd1;
            lcd_wr_d     = 1'b0;
            settle_cnt_d = SETTLE_LOAD;
            state_d      = ST_SETTLE;
          end
        end
      end
      default: begin
        lcd_wr_d = 1'b0;
        state_d  = ST_ADDR;
      end
    endcase

    for (int m = 0; m < NUM_MODES; m++) begin
      mode_en_d[m] = (mode_d == 2'(m));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ADDR;
      settle_cnt <= 4'd0;
      index      <= 5'd0;
      mode       <= 2'd0;
      mode_en    <= NUM_MODES'(1);
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_wr     <= 1'b0;
      frame_done <= 1'b0;
      pend_next  <= 1'b0;
      pend_watch <= 1'b0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      index      <= index_d;
      mode       <= mode_d;
      mode_en    <= mode_en_d;
      lcd_data   <= lcd_data_d;
      lcd_rs     <= lcd_rs_d;
      lcd_wr     <= lcd_wr_d;
      frame_done <= frame_done_d;
      pend_next  <= pend_next_d;
      pend_watch <= pend_watch_d;
    end
  end

endmodule

// File: tb/tb_lcd_mode_scheduler.sv
// tb/tb_lcd_mode_scheduler.sv - directed self-checking bench for lcd_mode_scheduler
module tb_lcd_mode_scheduler;

  localparam int NUM_MODES = 4;
  localparam int SETTLE    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   mode_btn;
  logic                   en_time;
  logic [8*NUM_MODES-1:0] char_in;
  logic [4:0]             index;
  logic [1:0]             mode;
  logic [NUM_MODES-1:0]   mode_en;
  logic [7:0]             lcd_data;
  logic                   lcd_rs;
  logic                   lcd_wr;
  logic                   lcd_ready;
  logic                   frame_done;

  int n_checks = 0;
  int n_errors = 0;

  lcd_mode_scheduler #(.NUM_MODES(NUM_MODES), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_btn   (mode_btn),
    .en_time    (en_time),
    .char_in    (char_in),
    .index      (index),
    .mode       (mode),
    .mode_en    (mode_en),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_wr     (lcd_wr),
    .lcd_ready  (lcd_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_for(input int idx, input logic rs);
    int n = 0;
    while (!(lcd_wr && lcd_rs == rs && index == 5'(idx)) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check($sformatf("timeout_idx%0d", idx), 32'd0, 32'd1);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("timeout_frame", 32'd0, 32'd1);
  endtask

  task automatic get_xfer(output logic [13:0] rec);
    int n = 0;
    while (!(lcd_wr && lcd_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("timeout_xfer", 32'd0, 32'd1);
    rec = {lcd_rs, lcd_data, index};
    tick();
  endtask

  task automatic pulse_btn();
    mode_btn = 1'b1;
    tick();
    mode_btn = 1'b0;
  endtask

  initial begin
    logic [13:0] rec, exp;
    int n;

    rst = 1'b1; mode_btn = 1'b0; en_time = 1'b0; lcd_ready = 1'b0;
    char_in = {4{8'h41}};
    tick();
    tick();
    check("rst_wr", 32'(lcd_wr), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_index", 32'(index), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_mode_en", 32'(mode_en), 32'h1);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // First full frame: line commands and characters
    rst = 1'b0;
    lcd_ready = 1'b1;
    for (int t = 0; t < 34; t++) begin
      get_xfer(rec);
      if (t == 0)       exp = {1'b0, 8'h80, 5'd0};
      else if (t == 17) exp = {1'b0, 8'hC0, 5'd16};
      else if (t < 17)  exp = {1'b1, 8'h41, 5'(t - 1)};
      else              exp = {1'b1, 8'h41, 5'(t - 2)};
      check($sformatf("f1_xfer%0d", t), 32'(rec), 32'(exp));
    end
    check("f1_frame_done", 32'(frame_done), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 200);
    check("frame_period", 32'(n), 32'd98);

    // Back-pressure on the index-7 character write
    wait_for(7, 1'b1);
    lcd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d", k), 32'({lcd_wr, lcd_rs, lcd_data, index}),
            32'({1'b1, 1'b1, 8'h41, 5'd7}));
    end
    lcd_ready = 1'b1;
    tick();
    check("stall_release_index", 32'(index), 32'd8);
    check("stall_release_wr", 32'(lcd_wr), 32'd0);

    // Mode advance deferred to frame boundary
    wait_for(10, 1'b1);
    pulse_btn();
    check("btn_mode_hold", 32'(mode), 32'd0);
    wait_for(31, 1'b1);
    check("btn_mode_hold31", 32'(mode), 32'd0);
    wait_frame();
    check("btn_mode", 32'(mode), 32'd1);
    check("btn_mode_en", 32'(mode_en), 32'h2);

    // Three pulses in one frame advance once
    wait_for(5, 1'b1);  pulse_btn();
    wait_for(12, 1'b1); pulse_btn();
    wait_for(25, 1'b1); pulse_btn();
    wait_frame();
    check("multi_btn_mode", 32'(mode), 32'd2);
    check("multi_btn_mode_en", 32'(mode_en), 32'h4);

    // Mode 2 selects its own slice; en_time outside mode 1 is ignored
    char_in = {8'h33, 8'h32, 8'h31, 8'h30};
    for (int i = 0; i < 32; i++) begin
      wait_for(i, 1'b1);
      check($sformatf("m2_char%0d", i), 32'(lcd_data), 32'h32);
      if (i == 20) begin
        en_time = 1'b1;
        tick();
        en_time = 1'b0;
      end
    end
    wait_frame();
    check("en_time_ignored", 32'(mode), 32'd2);

    wait_for(3, 1'b1); pulse_btn();
    wait_frame();
    check("mode3", 32'(mode), 32'd3);
    check("mode3_en", 32'(mode_en), 32'h8);
    wait_for(3, 1'b1); pulse_btn();
    wait_frame();
    check("wrap_mode", 32'(mode), 32'd0);
    check("wrap_mode_en", 32'(mode_en), 32'h1);
    wait_for(3, 1'b1); pulse_btn();
    wait_frame();
    check("mode1_again", 32'(mode), 32'd1);

    // en_time and mode_btn together in set mode: return to watch wins
    wait_for(20, 1'b1);
    mode_btn = 1'b1;
    en_time = 1'b1;
    tick();
    mode_btn = 1'b0;
    en_time = 1'b0;
    wait_for(31, 1'b1);
    check("commit_hold", 32'(mode), 32'd1);
    wait_frame();
    check("commit_mode", 32'(mode), 32'd0);
    check("commit_mode_en", 32'(mode_en), 32'h1);

    // Reset in the middle of a write
    wait_for(3, 1'b1); pulse_btn();
    wait_frame();
    check("pre_rst_mode", 32'(mode), 32'd1);
    wait_for(22, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_wr", 32'(lcd_wr), 32'd0);
    check("midrst_index", 32'(index), 32'd0);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_mode_en", 32'(mode_en), 32'h1);
    wait_for(0, 1'b0);
    check("midrst_first_cmd", 32'(lcd_data), 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lcd_mode_scheduler.md
Name: lcd_mode_scheduler

Overview:
- Owns the 16x2 character LCD and shares it between up to four mode blocks (watch display, watch set, alarm, stopwatch). Each mode block returns one ASCII character for a 5-bit screen index.
- Selects the active mode and sweeps the index 0..31. It captures the active mode's character and writes it to the LCD with a ready/write handshake, inserting DDRAM line-address commands.
- Returns to watch mode when the set block commits a time (`en_time`).

Parameters:
- NUM_MODES, 4, number of mode blocks sharing the display (2..4). Mode 0 is watch, mode 1 is set.
- SETTLE, 2, cycles between an index change and character capture (mode blocks register their output one cycle after index). Range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Synchronous, active-high.
- mode_btn  in  1  debounced single-cycle pulse: advance to the next mode
- en_time  in  1  single-cycle commit pulse from the set block
- char_in  in  8*NUM_MODES  character from each mode block. Mode m occupies bits [8m+7:8m].
- index  out  5  screen position presented to all mode blocks
- mode  out  2  active mode, binary
- mode_en  out  NUM_MODES  one-hot of mode
- lcd_data  out  8  LCD command or character byte
- lcd_rs  out  1  0 = command, 1 = character data
- lcd_wr  out  1  write request
- lcd_ready  in  1  LCD interface accepts the write
- frame_done  out  1  one-cycle pulse after the index-31 character is accepted

Behaviour:
- All outputs are registered. All state changes occur on posedge clk only.
- Reset (checked before anything else, any state, mid-transfer included):
  - State goes to ADDR with line 0 pending. index=0, mode=0, mode_en=one-hot bit 0.
  - lcd_wr=0, lcd_rs=0, lcd_data=0x00, frame_done=0. Pending-mode flags are cleared.
  - lcd_wr deasserts at the same edge; an in-flight write is abandoned.
- Handshake:
  - A transfer completes at an edge where lcd_wr=1 and lcd_ready=1.
  - While lcd_wr=1 and lcd_ready=0: lcd_wr, lcd_rs and lcd_data hold stable.
  - lcd_wr is never asserted in two consecutive transfers without the registered state advancing.
- FSM states: ADDR, SETTLE, CHAR.
  - ADDR:
    - lcd_wr=1, lcd_rs=0, lcd_data=0x80 if index<16, else 0xC0.
    - On transfer: go to SETTLE and load the settle counter with SETTLE-1.
  - SETTLE:
    - lcd_wr=0. Counter decrements each cycle.
    - At 0: latch char_in slice [8*mode+7:8*mode] into lcd_data, set lcd_rs=1, go to CHAR.
  - CHAR:
    - lcd_wr=1. On transfer:
      - index 15: index becomes 16, go to ADDR (line-2 command).
      - index 31: index wraps to 0, frame_done=1 for one cycle, apply the mode update, go to ADDR.
      - otherwise: index+1, go to SETTLE.
- Frame timing with lcd_ready tied 1: 2 + 32*(SETTLE+1) cycles per frame (98 cycles at SETTLE=2).
- Mode update, applied only at the index-31 transfer so a frame never mixes modes:
  - mode_btn sets pend_next. en_time while mode==1 sets pend_watch. Both flags are sticky until applied.
  - At the frame boundary, pend_watch takes priority: mode=0.
  - Else if pend_next: mode=mode+1, wrapping NUM_MODES-1 to 0.
  - Both flags clear at the boundary. mode_en updates at the same edge as mode.
  - mode_btn and en_time in the same cycle: both flags set; pend_watch wins.
  - en_time while mode!=1 is ignored.
  - Multiple mode_btn pulses within one frame advance the mode by one only.
- Index wrap-around: index is 5-bit and wraps 31 to 0, never exceeding 31.
- lcd_data is unchanged during SETTLE and keeps the last written byte.

Test Plan:
- Reset, then lcd_ready=1 and all char_in=0x41 → first write rs=0 data=0x80; 16 writes rs=1 data=0x41; then rs=0 data=0xC0, 16 chars; frame_done pulses at cycle 98.
- lcd_ready held 0 for 5 cycles during a CHAR write at index 7 → lcd_wr, lcd_rs, lcd_data and index stay constant; the transfer completes on the first ready cycle and index becomes 8.
- mode_btn pulse at index 10 of a mode-0 frame → mode stays 0 until the index-31 transfer, then mode=1 and mode_en=0010. Three pulses in one frame → mode=1 only. mode=3 plus a pulse → wraps to 0.
- mode=1, en_time together with mode_btn at index 20 → at the frame boundary mode=0. en_time with mode=2 → no change.
- Per-mode char_in distinct (0x30 + m), mode=2 → every data write in the frame is 0x32.
- rst asserted for one cycle while lcd_wr=1 at index 22 → the next edge gives lcd_wr=0, index=0, mode=0, and the next write is rs=0 data=0x80.
